// File: rtl/mem_wb_writeback.sv
// rtl/mem_wb_writeback.sv - MEM/WB stage: load formatting, destination select, writeback FIFO
module mem_wb_writeback #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       opcode,
    input  logic [4:0]       rt,
    input  logic [4:0]       rd,
    input  logic             RegDst,
    input  logic             RegWrite,
    input  logic             MemToReg,
    input  logic [31:0]      alu_result,
    input  logic [31:0]      mem_read_data,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [4:0]       wb_addr,
    output logic [31:0]      wb_data,
    output logic             misalign,
    output logic [CNT_W-1:0] retired_cnt
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr, rd_ptr, wr_ptr_nx, rd_ptr_nx;
    logic [4:0]   addr_mem [DEPTH];
    logic [31:0]  data_mem [DEPTH];
    logic         full, empty, accept, push, pop;
    logic [4:0]   dest;
    logic         is_half, misal_ld;
    logic [7:0]   sel_byte;
    logic [15:0]  sel_half;
    logic [31:0]  fmt_data, new_data;

    // Wrap bit distinguishes full from empty when the index bits match
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty    = (wr_ptr == rd_ptr);
    assign in_ready = !full;
    assign wb_valid = !empty;

    assign accept   = in_valid && in_ready;
    assign dest     = RegDst ? rd : rt;
    assign is_half  = (opcode == 6'h21) || (opcode == 6'h25);
    assign misal_ld = MemToReg && is_half && alu_result[0];
    // Dropped instructions are still consumed; only useful writes occupy a slot
    assign push     = accept && RegWrite && (dest != 5'd0) && !misal_ld;
    assign pop      = wb_valid && wb_ready;

    assign wr_ptr_nx = wr_ptr + {{AW{1'b0}}, push};
    assign rd_ptr_nx = rd_ptr + {{AW{1'b0}}, pop};

    // Little-endian lane extraction for sub-word loads
    always_comb begin
        sel_byte = mem_read_data[7:0];
        case (alu_result[1:0])
            2'd0: sel_byte = mem_read_data[7:0];
            2'd1: sel_byte = mem_read_data[15:8];
            2'd2: sel_byte = mem_read_data[23:16];
            2'd3: sel_byte = mem_read_data[31:24];
            default: sel_byte = mem_read_data[7:0];
        endcase
        sel_half = alu_result[1] ? mem_read_data[31:16] : mem_read_data[15:0];
    end

    // Sign/zero extension by opcode; anything not a sub-word load takes the full word
    always_comb begin
        fmt_data = mem_read_data;
        case (opcode)
            6'h20:   fmt_data = {{24{sel_byte[7]}}, sel_byte};
            6'h24:   fmt_data = {24'd0, sel_byte};
            6'h21:   fmt_data = {{16{sel_half[15]}}, sel_half};
            6'h25:   fmt_data = {16'd0, sel_half};
            default: fmt_data = mem_read_data;
        endcase
        new_data = MemToReg ? fmt_data : alu_result;
    end

    // Storage array; contents are meaningless until written, so no reset
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr[AW-1:0]] <= dest;
            data_mem[wr_ptr[AW-1:0]] <= new_data;
        end
    end

    // Pointers, sticky misalign flag and retire counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            misalign    <= 1'b0;
            retired_cnt <= '0;
        end else begin
            wr_ptr <= wr_ptr_nx;
            rd_ptr <= rd_ptr_nx;
            if (accept && misal_ld) begin
                misalign <= 1'b1;
            end
            if (pop) begin
                retired_cnt <= retired_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Registered head copy: tracks the next head, bypassing the array when the
    // incoming write becomes the head, and holds its last value when empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_addr <= 5'd0;
            wb_data <= 32'd0;
        end else if (wr_ptr_nx != rd_ptr_nx) begin
            if (push && (rd_ptr_nx == wr_ptr)) begin
                wb_addr <= dest;
                wb_data <= new_data;
            end else begin
                wb_addr <= addr_mem[rd_ptr_nx[AW-1:0]];
                wb_data <= data_mem[rd_ptr_nx[AW-1:0]];
            end
        end
    end

endmodule
